// File: rtl/trash_fetch_decode_if.sv
// ---------------------------------------------------------------------------
// trash_fetch_decode_if
//   Bundle of every non-clock/reset signal of the trash fetch/decode stage.
//   The "master" modport is the fetch/decode stage itself: it consumes the
//   load/run/redirect controls and drives the decoded-instruction stream.
//   The "slave" modport is the surrounding logic: loader, execute core, or
//   a testbench.
//
//   run            run/load mode select (0 = load, 1 = fetch)
//   prog_we        load-mode byte write strobe
//   prog_wdata     byte written at the load pointer
//   redirect_valid execute requests a jump
//   redirect_addr  jump target byte address (bit 0 ignored)
//   out_valid      decoded instruction available
//   out_ready      execute accepts the presented instruction
//   out_pc         byte address of the presented instruction
//   out_exec       instr[0]; 0 forces out_op to NOOP
//   out_op         instr[3:1], or 0 when out_exec = 0
//   out_a/b/c      instr[7:4], instr[11:8], instr[15:12]
//   out_data       instr[15:8]
//   halted         HALT instruction accepted (optional feature)
// ---------------------------------------------------------------------------
interface trash_fetch_decode_if #(
   parameter int PC_W = 3
);
   logic            run;
   logic            prog_we;
   logic [7:0]      prog_wdata;
   logic            redirect_valid;
   logic [PC_W-1:0] redirect_addr;
   logic            out_valid;
   logic            out_ready;
   logic [PC_W-1:0] out_pc;
   logic            out_exec;
   logic [2:0]      out_op;
   logic [3:0]      out_a;
   logic [3:0]      out_b;
   logic [3:0]      out_c;
   logic [7:0]      out_data;
   logic            halted;

   modport master (
      input  run, prog_we, prog_wdata, redirect_valid, redirect_addr, out_ready,
      output out_valid, out_pc, out_exec, out_op, out_a, out_b, out_c, out_data, halted
   );

   modport slave (
      output run, prog_we, prog_wdata, redirect_valid, redirect_addr, out_ready,
      input  out_valid, out_pc, out_exec, out_op, out_a, out_b, out_c, out_data, halted
   );
endinterface

// File: rtl/trash_fetch_decode.sv
// ---------------------------------------------------------------------------
// trash_fetch_decode
//   Instruction fetch/decode stage in front of the trash execute core.
//   Holds a byte-wide program store that is filled serially while stopped
//   (run = 0). While running it fetches 16-bit little-endian instructions
//   {store[pc+1], store[pc]}, splits them into fields and presents them to
//   execute through a valid/ready handshake. Execute may redirect the stream
//   (JUMP/JUMPIF), which drops the instruction currently presented.
//
//   Ports:
//     clk_i   clock, all state on its rising edge
//     rst_i   asynchronous active-high reset (store cleared as well)
//     bus_io  trash_fetch_decode_if.master (controls in, decoded stream out)
//
//   Optional feature: define TRASH_FETCH_HALT_EN to treat the encoding
//   exec=1, op=0, data=8'hFF as HALT. When undefined it is a plain NOOP and
//   halted stays 0.
// ---------------------------------------------------------------------------
module trash_fetch_decode #(
   parameter int PROG_BYTES = 8,
   parameter int PC_W       = 3
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   trash_fetch_decode_if.master bus_io
);

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] load_ptr_q, load_ptr_d;
   logic [PC_W-1:0] out_pc_q, out_pc_d;
   logic [15:0]     instr_q, instr_d;
   logic            valid_q, valid_d;
   logic            halted_q, halted_d;

   logic [7:0]      store_q [PROG_BYTES];
   logic            store_we;
   logic [15:0]     fetch_word;
   logic            halt_accept;
   logic            go_load;

   // pc is always even, so pc|1 addresses the high byte of the pair.
   assign fetch_word = {store_q[pc_q | PC_W'(1)], store_q[pc_q]};

`ifdef TRASH_FETCH_HALT_EN
   // HALT is presented like any instruction; it takes effect when accepted.
   assign halt_accept = valid_q && bus_io.out_ready && instr_q[0] &&
                        (instr_q[3:1] == 3'd0) && (instr_q[15:8] == 8'hFF);
`else
   assign halt_accept = 1'b0;
`endif

   // Dropping run leaves FETCH/HALT on the next edge regardless of anything else.
   assign go_load = (state_q != ST_LOAD) && !bus_io.run;

   // ------------------------------------------------------------------
   // Next-state / datapath logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      load_ptr_d = load_ptr_q;
      out_pc_d   = out_pc_q;
      instr_d    = instr_q;
      valid_d    = valid_q;
      halted_d   = halted_q;
      store_we   = 1'b0;

      if (go_load) begin
         // Any in-flight output is discarded on the way back to LOAD.
         state_d  = ST_LOAD;
         pc_d     = '0;
         out_pc_d = '0;
         instr_d  = '0;
         valid_d  = 1'b0;
         halted_d = 1'b0;
      end else begin
         case (state_q)
            ST_LOAD: begin
               if (bus_io.run) begin
                  state_d    = ST_FETCH;
                  pc_d       = '0;
                  load_ptr_d = '0;
               end else if (bus_io.prog_we) begin
                  store_we   = 1'b1;
                  load_ptr_d = load_ptr_q + PC_W'(1);
               end
            end

            ST_FETCH: begin
               if (bus_io.redirect_valid) begin
                  // Presented instruction is dropped even if accepted this edge.
                  valid_d = 1'b0;
                  pc_d    = bus_io.redirect_addr & ~PC_W'(1);
               end else if (halt_accept) begin
                  state_d  = ST_HALT;
                  valid_d  = 1'b0;
                  halted_d = 1'b1;
               end else if (!valid_q || bus_io.out_ready) begin
                  instr_d  = fetch_word;
                  out_pc_d = pc_q;
                  valid_d  = 1'b1;
                  pc_d     = pc_q + PC_W'(2);
               end
            end

            ST_HALT: begin
               // Only run=0 (handled above) or reset leave HALT.
               valid_d = 1'b0;
            end

            default: begin
               state_d = ST_LOAD;
               valid_d = 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= ST_LOAD;
         pc_q       <= '0;
         load_ptr_q <= '0;
         out_pc_q   <= '0;
         instr_q    <= '0;
         valid_q    <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         load_ptr_q <= load_ptr_d;
         out_pc_q   <= out_pc_d;
         instr_q    <= instr_d;
         valid_q    <= valid_d;
         halted_q   <= halted_d;
      end
   end

   // Program store: one register per byte because reset must clear it.
   generate
      for (genvar gi = 0; gi < PROG_BYTES; gi++) begin : g_store
         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               store_q[gi] <= 8'h00;
            end else if (store_we && (load_ptr_q == PC_W'(gi))) begin
               store_q[gi] <= bus_io.prog_wdata;
            end
         end
      end
   endgenerate

   // ------------------------------------------------------------------
   // Decoded outputs
   // ------------------------------------------------------------------
   assign bus_io.out_valid = valid_q;
   assign bus_io.out_pc    = out_pc_q;
   assign bus_io.out_exec  = instr_q[0];
   assign bus_io.out_op    = instr_q[0] ? instr_q[3:1] : 3'd0;
   assign bus_io.out_a     = instr_q[7:4];
   assign bus_io.out_b     = instr_q[11:8];
   assign bus_io.out_c     = instr_q[15:12];
   assign bus_io.out_data  = instr_q[15:8];
   assign bus_io.halted    = halted_q;

endmodule

// File: tb/tb_trash_fetch_decode.sv
module tb_trash_fetch_decode;

   localparam int PB = 8;
   localparam int PW = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int checks   = 0;
   int failures = 0;
   int cycle    = 0;

   trash_fetch_decode_if #(.PC_W(PW)) bus ();

   trash_fetch_decode #(.PROG_BYTES(PB), .PC_W(PW)) dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .bus_io (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycle++;

   // ------------------------------------------------------------------
   // Reference model: program memory plus "what is on the wire" state.
   // mode: 0 = stopped/loading, 1 = streaming, 2 = halted.
   // ------------------------------------------------------------------
   int        m_mem [PB];
   int        m_lp;
   int        m_pc;
   int        m_mode;
   bit        m_valid;
   int        m_word;
   int        m_opc;
   bit        m_halted;

   function automatic bit is_halt_word(input int w);
`ifdef TRASH_FETCH_HALT_EN
      return ((w & 1) == 1) && (((w >> 1) & 7) == 0) && (((w >> 8) & 255) == 255);
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_reset();
      for (int i = 0; i < PB; i++) m_mem[i] = 0;
      m_lp = 0; m_pc = 0; m_mode = 0; m_valid = 0; m_word = 0; m_opc = 0; m_halted = 0;
   endtask

   initial model_reset();

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         model_reset();
      end else if (m_mode != 0 && !bus.run) begin
         m_mode = 0; m_pc = 0; m_valid = 0; m_word = 0; m_opc = 0; m_halted = 0;
      end else if (m_mode == 0) begin
         if (bus.run) begin
            m_mode = 1; m_pc = 0; m_lp = 0;
         end else if (bus.prog_we) begin
            m_mem[m_lp] = int'(bus.prog_wdata);
            m_lp = (m_lp + 1) % PB;
         end
      end else if (m_mode == 1) begin
         if (bus.redirect_valid) begin
            m_valid = 0;
            m_pc = int'(bus.redirect_addr) / 2 * 2;
         end else if (m_valid && bus.out_ready && is_halt_word(m_word)) begin
            $display("cycle %0d accept pc=%0d word=%04h (halt)", cycle, m_opc, m_word);
            m_mode = 2; m_valid = 0; m_halted = 1;
         end else if (!m_valid || bus.out_ready) begin
            if (m_valid)
               $display("cycle %0d accept pc=%0d word=%04h", cycle, m_opc, m_word);
            m_word  = m_mem[m_pc + 1] * 256 + m_mem[m_pc];
            m_opc   = m_pc;
            m_valid = 1;
            m_pc    = (m_pc + 2) % PB;
         end
      end
   end

   // ------------------------------------------------------------------
   // Cycle-by-cycle comparison on the falling edge
   // ------------------------------------------------------------------
   always @(negedge clk) begin
      logic [1:0]  act_ctl, exp_ctl;
      logic [30:0] act_f, exp_f;
      int          e_exec, e_op;
      act_ctl = {bus.out_valid, bus.halted};
      exp_ctl = {m_valid, m_halted};
      checks++;
      if (act_ctl !== exp_ctl) begin
         failures++;
         $display("FAIL ctl cycle=%0d valid/halted actual=%b required=%b", cycle, act_ctl, exp_ctl);
      end
      if (m_valid) begin
         e_exec = m_word & 1;
         e_op   = e_exec ? ((m_word >> 1) & 7) : 0;
         act_f  = {bus.out_pc, bus.out_exec, bus.out_op, bus.out_a, bus.out_b, bus.out_c, bus.out_data};
         exp_f  = {PW'(m_opc), 1'(e_exec), 3'(e_op), 4'(m_word >> 4), 4'(m_word >> 8),
                   4'(m_word >> 12), 8'(m_word >> 8)};
         checks++;
         if (act_f !== exp_f) begin
            failures++;
            $display("FAIL fields cycle=%0d actual=%h required=%h", cycle, act_f, exp_f);
         end
      end
   end

   // ------------------------------------------------------------------
   // Directed helpers
   // ------------------------------------------------------------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic write_byte(input logic [7:0] b);
      bus.prog_we    = 1'b1;
      bus.prog_wdata = b;
      step();
      bus.prog_we    = 1'b0;
   endtask

   initial begin
      logic [7:0] prog [8];
      prog = '{8'h03, 8'h12, 8'h05, 8'h34, 8'h0B, 8'h56, 8'h00, 8'h00};

      bus.run = 1'b0; bus.prog_we = 1'b0; bus.prog_wdata = 8'h00;
      bus.redirect_valid = 1'b0; bus.redirect_addr = '0; bus.out_ready = 1'b0;
      step(); step();
      rst = 1'b0;
      lit("reset_valid", 32'(bus.out_valid), 0);
      lit("reset_pc",    32'(bus.out_pc),    0);
      lit("reset_halt",  32'(bus.halted),    0);

      // Load the demo program
      for (int i = 0; i < 8; i++) write_byte(prog[i]);
      lit("load_valid", 32'(bus.out_valid), 0);

      // Stream with out_ready high
      bus.out_ready = 1'b1;
      bus.run = 1'b1;
      step();
      lit("enter_fetch_latency", 32'(bus.out_valid), 0);
      step();
      lit("c1_pc",   32'(bus.out_pc),   0);
      lit("c1_op",   32'(bus.out_op),   1);
      lit("c1_a",    32'(bus.out_a),    0);
      lit("c1_data", 32'(bus.out_data), 32'h12);
      step();
      lit("c2_pc", 32'(bus.out_pc), 2);
      lit("c2_op", 32'(bus.out_op), 2);
      lit("c2_b",  32'(bus.out_b),  4);
      lit("c2_c",  32'(bus.out_c),  3);
      step();
      lit("c3_pc", 32'(bus.out_pc), 4);
      lit("c3_op", 32'(bus.out_op), 5);
      step();
      lit("c4_pc",   32'(bus.out_pc),   6);
      lit("c4_exec", 32'(bus.out_exec), 0);
      lit("c4_op",   32'(bus.out_op),   0);
      step();
      lit("c5_wrap_pc", 32'(bus.out_pc), 0);
      lit("c5_valid",   32'(bus.out_valid), 1);

      // Backpressure at pc=2
      step();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         lit("stall_pc", 32'(bus.out_pc), 2);
         lit("stall_op", 32'(bus.out_op), 2);
      end
      bus.out_ready = 1'b1;
      step();
      lit("release_pc", 32'(bus.out_pc), 4);

      // Redirect to 3 (-> 2) while presenting pc=4
      bus.redirect_valid = 1'b1;
      bus.redirect_addr  = 3'd3;
      step();
      bus.redirect_valid = 1'b0;
      lit("redir_bubble", 32'(bus.out_valid), 0);
      step();
      lit("redir_valid", 32'(bus.out_valid), 1);
      lit("redir_pc",    32'(bus.out_pc),    2);

      // Drop run, write one byte, restart
      bus.run = 1'b0;
      step();
      lit("stop_valid", 32'(bus.out_valid), 0);
      write_byte(8'hA1);
      bus.run = 1'b1;
      step();
      step();
      lit("reload_pc",   32'(bus.out_pc),   0);
      lit("reload_a",    32'(bus.out_a),    32'hA);
      lit("reload_data", 32'(bus.out_data), 32'h12);
      step(); step();

      // Asynchronous reset mid-stream
      rst = 1'b1;
      #1;
      lit("async_rst_valid", 32'(bus.out_valid), 0);
      lit("async_rst_data",  32'(bus.out_data),  0);
      bus.run = 1'b0;
      step();
      rst = 1'b0;

      // HALT encoding at pc=2
      write_byte(8'h00); write_byte(8'h00); write_byte(8'h01); write_byte(8'hFF);
      bus.run = 1'b1;
      step(); step();
      step();
      lit("halt_word_pc",   32'(bus.out_pc),   2);
      lit("halt_word_data", 32'(bus.out_data), 32'hFF);
      step();
`ifdef TRASH_FETCH_HALT_EN
      lit("halt_flag",  32'(bus.halted),    1);
      lit("halt_valid", 32'(bus.out_valid), 0);
      bus.redirect_valid = 1'b1;
      step(); step();
      bus.redirect_valid = 1'b0;
      lit("halt_ignores_redirect", 32'(bus.out_valid), 0);
`else
      lit("noop_flag", 32'(bus.halted), 0);
      lit("noop_pc",   32'(bus.out_pc), 4);
      step();
      lit("noop_next_pc", 32'(bus.out_pc), 6);
`endif
      bus.run = 1'b0;
      step();
      lit("halt_clear", 32'(bus.halted), 0);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         int r;
         r = int'($urandom_range(0, 999));
         bus.out_ready      = ($urandom_range(0, 9) < 7);
         bus.redirect_valid = 1'b0;
         bus.prog_we        = 1'b0;
         if (r < 3) begin
            rst = 1'b1;
         end else begin
            rst = 1'b0;
         end
         if (!bus.run) begin
            bus.prog_we = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 7))
               0:       bus.prog_wdata = 8'hFF;
               1:       bus.prog_wdata = 8'h01;
               default: bus.prog_wdata = 8'($urandom);
            endcase
            if ($urandom_range(0, 9) == 0) bus.run = 1'b1;
         end else begin
            if ($urandom_range(0, 99) < 2) bus.run = 1'b0;
            if ($urandom_range(0, 99) < 8) begin
               bus.redirect_valid = 1'b1;
               bus.redirect_addr  = 3'($urandom);
            end
         end
         step();
      end
      rst = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
